// File: rtl/dogm240_write_arbiter.sv
// dogm240_write_arbiter: round-robin sharing of the display write port between CPU writes and a frame-buffer fill engine
module dogm240_write_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 960
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              cpu_req_in,
  input  logic [ADDR_W-1:0] cpu_addr_in,
  input  logic [DATA_W-1:0] cpu_data_in,
  output logic              cpu_ack_o,
  input  logic              fill_start_in,
  input  logic [DATA_W-1:0] fill_pattern_in,
  output logic              fill_busy_o,
  output logic              fill_done_o,
  output logic [ADDR_W-1:0] disp_addr_o,
  output logic [DATA_W-1:0] disp_data_o,
  output logic              disp_we_o
);
  typedef enum logic {IDLE, FILL} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] pattern;
  logic last_fill, in_range, blocked, fill_gnt, last_gnt;
  // CPU is held off from words the fill has not reached yet, so its data is never overwritten
  always_comb begin
    in_range  = cpu_addr_in < ADDR_W'(DEPTH);
    blocked   = in_range && cpu_addr_in >= ptr;
    cpu_ack_o = state == IDLE ? cpu_req_in : cpu_req_in && !blocked && last_fill;
    fill_gnt  = state == FILL && !cpu_ack_o;
    last_gnt  = fill_gnt && ptr == ADDR_W'(DEPTH - 1);
    state_nx  = state == IDLE ? (fill_start_in ? FILL : IDLE) : (last_gnt ? IDLE : FILL);
  end
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state       <= IDLE;
      ptr         <= '0;
      pattern     <= '0;
      last_fill   <= 1'b1;
      disp_addr_o <= '0;
      disp_data_o <= '0;
      disp_we_o   <= 1'b0;
      fill_busy_o <= 1'b0;
      fill_done_o <= 1'b0;
    end else begin
      state       <= state_nx;
      disp_we_o   <= fill_gnt || (cpu_ack_o && in_range);
      fill_done_o <= last_gnt;
      if (fill_gnt) begin
        disp_addr_o <= ptr;
        disp_data_o <= pattern;
        ptr         <= ptr + 1'b1;
      end else if (cpu_ack_o && in_range) begin
        disp_addr_o <= cpu_addr_in;
        disp_data_o <= cpu_data_in;
      end
      if (state == FILL) last_fill <= fill_gnt;
      if (state == IDLE && fill_start_in) begin
        ptr         <= '0;
        pattern     <= fill_pattern_in;
        fill_busy_o <= 1'b1;
      end
      if (last_gnt) fill_busy_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dogm240_write_arbiter.sv
// tb_dogm240_write_arbiter: directed scoreboard bench for the display write arbiter
module tb_dogm240_write_arbiter;
  localparam int AW = 10, DW = 16, DEPTH = 960;
  logic clk_in = 1'b0, reset_in, cpu_req_in, cpu_ack_o, fill_start_in;
  logic fill_busy_o, fill_done_o, disp_we_o;
  logic [AW-1:0] cpu_addr_in, disp_addr_o;
  logic [DW-1:0] cpu_data_in, fill_pattern_in, disp_data_o;
  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d; logic done;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  int n_cmp = 0, n_err = 0, done_cnt = 0, d0, busy_cnt, acks, waits, cycles;
  bit mon_on = 0, seen, got;
  dogm240_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .cpu_req_in(cpu_req_in), .cpu_addr_in(cpu_addr_in),
    .cpu_data_in(cpu_data_in), .cpu_ack_o(cpu_ack_o), .fill_start_in(fill_start_in),
    .fill_pattern_in(fill_pattern_in), .fill_busy_o(fill_busy_o), .fill_done_o(fill_done_o),
    .disp_addr_o(disp_addr_o), .disp_data_o(disp_data_o), .disp_we_o(disp_we_o)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk_in);
    #1;
  endtask
  task automatic push(input int a, input logic [DW-1:0] d, input logic done);
    q.push_back('{a: AW'(a), d: d, done: done});
  endtask
  task automatic fill_exp(input int lo, input int hi, input logic [DW-1:0] pat);
    for (int a = lo; a <= hi; a++) push(a, pat, a == DEPTH - 1);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_we"}, disp_we_o, 0);
    chk({tag, "_addr"}, disp_addr_o, 0);
    chk({tag, "_data"}, disp_data_o, 0);
    chk({tag, "_busy"}, fill_busy_o, 0);
    chk({tag, "_done"}, fill_done_o, 0);
    chk({tag, "_ack"}, cpu_ack_o, 0);
  endtask
  always @(negedge clk_in) if (mon_on) begin
    if (fill_done_o) done_cnt++;
    if (disp_we_o) begin
      if (q.size() == 0) chk("spurious_we_queue", q.size(), 1);
      else begin
        mon_e = q.pop_front();
        chk("wr_addr", disp_addr_o, mon_e.a);
        chk("wr_data", disp_data_o, mon_e.d);
        chk("wr_done", fill_done_o, mon_e.done);
      end
    end else chk("done_without_we", fill_done_o, 0);
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    reset_in = 1; cpu_req_in = 0; cpu_addr_in = '0; cpu_data_in = '0;
    fill_start_in = 0; fill_pattern_in = '0;
    repeat (3) step;
    reset_in = 0;
    chk_zero("reset");
    mon_on = 1;
    // idle CPU writes, back to back
    cpu_req_in = 1; cpu_addr_in = 5; cpu_data_in = 16'hA5A5;
    @(negedge clk_in); chk("idle_ack0", cpu_ack_o, 1); push(5, 16'hA5A5, 0); step;
    cpu_addr_in = 6; cpu_data_in = 16'h1111;
    @(negedge clk_in); chk("idle_ack1", cpu_ack_o, 1); push(6, 16'h1111, 0); step;
    cpu_addr_in = 7; cpu_data_in = 16'h2222;
    @(negedge clk_in); chk("idle_ack2", cpu_ack_o, 1); push(7, 16'h2222, 0); step;
    // out-of-range in IDLE: acked, dropped, outputs hold
    cpu_addr_in = 1000; cpu_data_in = 16'hDEAD;
    @(negedge clk_in); chk("oor_idle_ack", cpu_ack_o, 1); step;
    cpu_req_in = 0;
    chk("oor_idle_we", disp_we_o, 0);
    chk("hold_addr", disp_addr_o, 7);
    chk("hold_data", disp_data_o, 16'h2222);
    repeat (2) step;
    chk("idle_drain", q.size(), 0);
    // fill aborted by reset at pointer 300, with an ignored restart mid-fill
    fill_exp(0, 299, 16'h5A5A);
    d0 = done_cnt;
    fill_start_in = 1; fill_pattern_in = 16'h5A5A; step;
    fill_start_in = 0; fill_pattern_in = '0;
    chk("abort_busy", fill_busy_o, 1);
    for (int i = 1; i <= 300; i++) begin
      fill_start_in = (i == 100);
      fill_pattern_in = (i == 100) ? 16'hFFFF : 16'h0000;
      step;
    end
    fill_start_in = 0; reset_in = 1; step;
    reset_in = 0;
    chk_zero("abort");
    step;
    chk("abort_drain", q.size(), 0);
    chk("abort_no_done", done_cnt - d0, 0);
    // fill alone restarts from address 0
    fill_exp(0, DEPTH - 1, 16'h0000);
    d0 = done_cnt;
    fill_start_in = 1; fill_pattern_in = 16'h0000; step;
    fill_start_in = 0;
    busy_cnt = 0; seen = 0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      if (fill_busy_o) busy_cnt++;
      if (fill_done_o) seen = 1;
      else step;
    end
    chk("fill_done_seen", seen, 1);
    chk("fill_busy_cycles", busy_cnt, DEPTH);
    chk("fill_busy_at_done", fill_busy_o, 0);
    step;
    chk("fill_drain", q.size(), 0);
    chk("fill_done_once", done_cnt - d0, 1);
    // fill with continuous CPU writes to word 0: grants alternate
    push(0, 16'hC3C3, 0);
    for (int k = 0; k < DEPTH - 1; k++) begin
      push(0, DW'(16'h1000 + k), 0);
      push(k + 1, 16'hC3C3, k + 1 == DEPTH - 1);
    end
    fill_start_in = 1; fill_pattern_in = 16'hC3C3; step;
    fill_start_in = 0;
    cpu_req_in = 1; cpu_addr_in = 0; cpu_data_in = 16'h1000;
    acks = 0; seen = 0; cycles = 0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk_in);
      if (fill_done_o) begin
        seen = 1; cpu_req_in = 0;
      end else begin
        got = cpu_ack_o; cycles++;
        step;
        if (got) begin acks++; cpu_data_in++; end
      end
    end
    chk("alt_done_seen", seen, 1);
    chk("alt_cpu_acks", acks, DEPTH - 1);
    chk("alt_cycles", cycles, 2 * DEPTH - 1);
    repeat (2) step;
    chk("alt_drain", q.size(), 0);
    // CPU write ahead of the fill pointer waits, then an out-of-range write in FILL
    fill_exp(0, 900, 16'h7E7E);
    push(900, 16'hBEEF, 0);
    fill_exp(901, DEPTH - 1, 16'h7E7E);
    fill_start_in = 1; fill_pattern_in = 16'h7E7E; step;
    fill_start_in = 0;
    repeat (10) step;
    cpu_req_in = 1; cpu_addr_in = 900; cpu_data_in = 16'hBEEF;
    got = 0; waits = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk_in);
      if (cpu_ack_o) got = 1;
      else waits++;
      step;
    end
    chk("blk_acked", got, 1);
    chk("blk_waits", waits, 891);
    cpu_addr_in = 1000; cpu_data_in = 16'hDEAD;
    got = 0; waits = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk_in);
      if (cpu_ack_o) got = 1;
      else waits++;
      step;
    end
    cpu_req_in = 0;
    chk("oor_fill_acked", got, 1);
    chk("oor_fill_waits", waits, 1);
    seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk_in);
      if (fill_done_o) seen = 1;
      else step;
    end
    chk("blk_done_seen", seen, 1);
    repeat (2) step;
    chk("blk_drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dogm240_write_arbiter.md
Name: dogm240_write_arbiter

Overview:
- Shares the single write port of the DOGM240 display controller (10-bit word address, 16-bit data, write enable) between two requesters.
- Requester 1 is the CPU/emulator write path.
- Requester 2 is an internal fill engine that clears or pattern-fills the whole 240x64 frame buffer (960 words).
- The block sits directly in front of display_dogm240 and drives its addr_in/data_in/we_in.

Parameters:
ADDR_W, 10, display word address width
DATA_W, 16, display data width
DEPTH, 960, number of frame-buffer words (240x64/16)

Ports:
clk_in  input  1  system clock
reset_in  input  1  synchronous reset, active-high
cpu_req_in  input  1  CPU write request; held until acknowledged
cpu_addr_in  input  ADDR_W  CPU word address
cpu_data_in  input  DATA_W  CPU write data
cpu_ack_o  output  1  combinational grant; transfer occurs on the edge where cpu_req_in & cpu_ack_o
fill_start_in  input  1  one-cycle fill command
fill_pattern_in  input  DATA_W  fill word, sampled with fill_start_in
fill_busy_o  output  1  fill in progress
fill_done_o  output  1  one-cycle pulse when fill completes
disp_addr_o  output  ADDR_W  to display addr_in (registered)
disp_data_o  output  DATA_W  to display data_in (registered)
disp_we_o  output  1  to display we_in (registered)

Behaviour:
- Reset (synchronous, any state, including mid-fill):
  - All outputs 0; state IDLE; fill pointer 0; round-robin flag = CPU-preferred.
  - A fill in progress is aborted with no fill_done_o pulse.
- FSM has two states: IDLE and FILL. At most one display write per cycle.
- Write latency: a grant in cycle t produces disp_we_o=1 in cycle t+1 with the granted addr/data. disp_we_o=0 in every other cycle.
- disp_addr_o/disp_data_o hold their last values when disp_we_o=0.
- IDLE:
  - cpu_ack_o = cpu_req_in.
  - fill_start_in=1 latches fill_pattern_in, clears the fill pointer and moves to FILL next cycle.
  - A CPU request in the same cycle is still served.
- FILL:
  - Each cycle, exactly one of CPU or fill is granted.
  - CPU is eligible when cpu_req_in=1 and it is not blocked.
  - Blocked: cpu_addr_in < DEPTH and cpu_addr_in >= fill pointer, i.e. the target word is not yet filled. This guarantees the CPU data is never overwritten by the fill.
  - Round-robin: if CPU is eligible and the previous FILL-state grant went to fill, grant CPU; otherwise grant fill. With CPU continuously eligible, grants therefore alternate CPU, fill, CPU, ...
  - A fill grant writes the latched pattern at the fill pointer, then increments the pointer.
  - The grant of address DEPTH-1 is the last. Next cycle: state IDLE, fill_busy_o=0, fill_done_o=1 for one cycle, coincident with disp_we_o for address DEPTH-1.
  - fill_start_in is ignored while in FILL; no restart and no pattern change.
- fill_busy_o is registered: 1 from the cycle after fill_start_in through the cycle in which the last fill grant is made.
- Out-of-range CPU address (>= DEPTH):
  - Acknowledged under the normal rules (never blocked).
  - Dropped: disp_we_o stays 0 for that slot.
  - In FILL, a dropped CPU slot still counts as a CPU grant for round-robin.
- Fill duration with no CPU traffic: exactly DEPTH consecutive disp_we_o cycles, addresses 0..DEPTH-1 ascending.

Test Plan:
- Reset then idle CPU writes: req addr 5 data 16'hA5A5 -> ack same cycle; next cycle disp_we_o=1, addr 5, data A5A5; back-to-back requests give one write per cycle.
- Fill alone: fill_start_in with pattern 16'h0000 -> busy next cycle; 960 writes at addr 0..959, all 0000; fill_done_o pulses once with busy=0; busy high for exactly 960 cycles.
- Fill with continuous CPU writes to addr 0 (already filled) -> grants alternate CPU/fill; fill completes in 1920 cycles; final word 0 equals the last CPU data.
- CPU write to addr 900 at fill pointer 10 -> cpu_ack_o held 0 until pointer reaches 901; then acked; the written word persists after fill_done_o.
- CPU write to addr 1000 (out of range) -> acked; no disp_we_o for it, in both IDLE and FILL.
- Reset asserted at fill pointer 300 -> next cycle all outputs 0, no fill_done_o; a second fill_start_in restarts from addr 0. A fill_start_in issued mid-fill is ignored and the pattern is unchanged.
